if_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the decode stage.
- Owns the fetch PC and the next-PC selection (pcsource / bpc / jpc / jrpc fed back from decode).
- Drives an SRAM-like instruction-memory request/response handshake and produces the IF/ID pipeline register (instruction, PC, valid).
- Honours decode-stage stalls and the MIPS branch delay slot.

---
 rtl/if_stage_pkg.sv | 23 ++
 rtl/if_stage_npc_sel.sv | 40 ++++
 rtl/if_stage.sv | 169 ++++++++++++++++
 tb/tb_if_stage.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared encodings for the instruction-fetch stage: next-PC selector codes,
// default boot address and fetch state machine states.
package if_stage_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'hBFC0_0000;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JR  = 2'b10;
    localparam logic [1:0] PC_J   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        HOLD = 2'b11
    } fetch_state_e;

    function automatic logic pc_misaligned(input logic [31:0] pc);
        return (pc[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/if_stage_npc_sel.sv
// Next-PC selection: a remembered redirect wins, then a live decode-stage
// redirect, otherwise the sequential PC (wrapping at 2^32).
module if_stage_npc_sel
    import if_stage_pkg::*;
(
    input  logic [31:0] fetch_pc_i,
    input  logic        pending_i,
    input  logic [31:0] ptarget_i,
    input  logic        id_valid_i,
    input  logic [1:0]  pcsource_i,
    input  logic [31:0] bpc_i,
    input  logic [31:0] jpc_i,
    input  logic [31:0] jrpc_i,
    output logic        redir_live_o,
    output logic [31:0] target_o,
    output logic [31:0] npc_o
);

    logic [31:0] seq_pc_s;

    // Target decode and next-PC priority mux
    always_comb begin
        seq_pc_s = fetch_pc_i + 32'd4;
        case (pcsource_i)
            PC_BR:   target_o = bpc_i;
            PC_JR:   target_o = jrpc_i;
            PC_J:    target_o = jpc_i;
            default: target_o = seq_pc_s;
        endcase
        redir_live_o = id_valid_i && (pcsource_i != PC_SEQ);
        if (pending_i) begin
            npc_o = ptarget_i;
        end else if (redir_live_o) begin
            npc_o = target_o;
        end else begin
            npc_o = seq_pc_s;
        end
    end

endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: owns the fetch PC, drives the instruction
// memory handshake and fills the IF/ID register, honouring stalls and delay slots.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned PCSRC_W  = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               id_valid,
    input  logic [PCSRC_W-1:0] pcsource,
    input  logic [31:0]        bpc,
    input  logic [31:0]        jpc,
    input  logic [31:0]        jrpc,
    output logic               inst_req,
    output logic [31:0]        inst_addr,
    input  logic               inst_addr_ok,
    input  logic               inst_data_ok,
    input  logic [31:0]        inst_rdata,
    output logic [31:0]        o_inst,
    output logic [31:0]        o_pc,
    output logic               o_valid,
    output logic               o_adel
);

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  ptarget_q, ptarget_d;
    logic [31:0]  hold_q, hold_d;
    logic         pending_q, pending_d;
    logic         req_q, req_d;
    logic [31:0]  inst_q, inst_d;
    logic [31:0]  pc_q, pc_d;
    logic         valid_q, valid_d;
    logic         adel_q, adel_d;

    logic         handoff_s;
    logic [31:0]  hand_inst_s;
    logic         hand_adel_s;
    logic         redir_live_s;
    logic [31:0]  target_s;
    logic [31:0]  npc_s;

    if_stage_npc_sel u_npc_sel (
        .fetch_pc_i   (fetch_pc_q),
        .pending_i    (pending_q),
        .ptarget_i    (ptarget_q),
        .id_valid_i   (id_valid),
        .pcsource_i   (pcsource),
        .bpc_i        (bpc),
        .jpc_i        (jpc),
        .jrpc_i       (jrpc),
        .redir_live_o (redir_live_s),
        .target_o     (target_s),
        .npc_o        (npc_s)
    );

    // Fetch FSM next state, redirect bookkeeping and IF/ID next values
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        handoff_s   = 1'b0;
        hand_inst_s = 32'h0000_0000;
        hand_adel_s = 1'b0;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (pc_misaligned(fetch_pc_q)) begin
                    // no bus request: the address error itself is the result
                    handoff_s   = !stall;
                    hand_adel_s = 1'b1;
                end else if (inst_addr_ok) begin
                    state_d = WAIT;
                end else begin
                    state_d = REQ;
                end
            end
            WAIT: begin
                if (inst_data_ok && !stall) begin
                    handoff_s   = 1'b1;
                    hand_inst_s = inst_rdata;
                end else if (inst_data_ok) begin
                    hold_d  = inst_rdata;
                    state_d = HOLD;
                end else begin
                    state_d = WAIT;
                end
            end
            HOLD: begin
                if (!stall) begin
                    handoff_s   = 1'b1;
                    hand_inst_s = hold_q;
                end else begin
                    state_d = HOLD;
                end
            end
            default: state_d = IDLE;
        endcase

        fetch_pc_d = fetch_pc_q;
        pending_d  = pending_q;
        ptarget_d  = ptarget_q;
        if (handoff_s) begin
            state_d    = REQ;
            fetch_pc_d = npc_s;
            pending_d  = 1'b0;
        end else if (redir_live_s) begin
            // delay slot still in flight: remember where to go after it
            pending_d = 1'b1;
            ptarget_d = target_s;
        end else begin
            pending_d = pending_q;
        end

        inst_d  = inst_q;
        pc_d    = pc_q;
        adel_d  = adel_q;
        valid_d = valid_q;
        if (stall) begin
            valid_d = valid_q;
        end else if (handoff_s) begin
            inst_d  = hand_inst_s;
            pc_d    = fetch_pc_q;
            adel_d  = hand_adel_s;
            valid_d = 1'b1;
        end else begin
            valid_d = 1'b0;
        end

        req_d = (state_d == REQ) && !pc_misaligned(fetch_pc_d);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            ptarget_q  <= 32'h0000_0000;
            hold_q     <= 32'h0000_0000;
            pending_q  <= 1'b0;
            req_q      <= 1'b0;
            inst_q     <= 32'h0000_0000;
            pc_q       <= 32'h0000_0000;
            valid_q    <= 1'b0;
            adel_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            ptarget_q  <= ptarget_d;
            hold_q     <= hold_d;
            pending_q  <= pending_d;
            req_q      <= req_d;
            inst_q     <= inst_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            adel_q     <= adel_d;
        end
    end

    assign inst_req  = req_q;
    assign inst_addr = fetch_pc_q;
    assign o_inst    = inst_q;
    assign o_pc      = pc_q;
    assign o_valid   = valid_q;
    assign o_adel    = adel_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a transaction-level fetch model and an
// SRAM-like memory responder whose latency and acceptance are scripted.
module tb_if_stage;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        reset, stall, id_valid;
    logic [1:0]  pcsource;
    logic [31:0] bpc, jpc, jrpc;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic [31:0] o_inst, o_pc;
    logic        o_valid, o_adel;

    int checks = 0;
    int fails  = 0;

    int          data_delay = 0;
    int          aok_hold   = 0;
    logic        stale_dok  = 1'b0;
    logic        dok_real   = 1'b0;
    logic        r_acc = 1'b0, r_out = 1'b0;
    logic [31:0] r_acc_addr = 32'h0, r_addr = 32'h0;
    int          r_dly = 0;

    logic        s_reset = 1'b1, s_stall = 1'b0, s_idv = 1'b0;
    logic        s_req = 1'b0, s_aok = 1'b0, s_dok = 1'b0;
    logic [1:0]  s_pcs = 2'b00;
    logic [31:0] s_bpc = 32'h0, s_jpc = 32'h0, s_jrpc = 32'h0;

    if_stage dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .id_valid     (id_valid),
        .pcsource     (pcsource),
        .bpc          (bpc),
        .jpc          (jpc),
        .jrpc         (jrpc),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .o_inst       (o_inst),
        .o_pc         (o_pc),
        .o_valid      (o_valid),
        .o_adel       (o_adel)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return (addr == RST_PC) ? 32'h2401_0001 : (addr ^ 32'h1234_5678);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_pc(input logic [31:0] pc);
        bit found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(posedge clk); #3;
            found = o_valid && (o_pc == pc);
        end
        if (!found) begin
            checks++; fails++;
            $display("FAIL wait_pc: no delivery of %h, o_pc is %h", pc, o_pc);
        end
    endtask

    task automatic wait_req();
        bit found = inst_req;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk); #3;
            found = inst_req;
        end
        if (!found) begin
            checks++; fails++;
            $display("FAIL wait_req: inst_req never rose, got %b expected 1", inst_req);
        end
    endtask

    // Memory responder: accepts per aok_hold, returns data data_delay cycles late
    initial begin
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata   = 32'h0;
        forever begin
            @(negedge clk); #1;
            inst_data_ok = 1'b0;
            dok_real     = 1'b0;
            if (reset) begin
                r_acc = 1'b0; r_out = 1'b0; inst_addr_ok = 1'b0;
            end else begin
                if (r_acc) begin
                    r_out = 1'b1; r_addr = r_acc_addr; r_dly = data_delay; r_acc = 1'b0;
                end
                if (r_out) begin
                    if (r_dly > 0) r_dly--;
                    else begin
                        inst_data_ok = 1'b1; dok_real = 1'b1;
                        inst_rdata = mem_word(r_addr); r_out = 1'b0;
                    end
                end
                inst_addr_ok = inst_req && (aok_hold == 0);
                if (inst_req && aok_hold > 0) aok_hold--;
                r_acc = inst_req && inst_addr_ok;
                r_acc_addr = inst_addr;
            end
            if (stale_dok) begin
                inst_data_ok = 1'b1; inst_rdata = 32'hDEAD_BEEF;
            end
        end
    end

    // Snapshot of everything the DUT will sample at the coming edge
    initial begin
        forever begin
            @(negedge clk); #3;
            s_reset = reset; s_stall = stall; s_idv = id_valid; s_pcs = pcsource;
            s_bpc = bpc; s_jpc = jpc; s_jrpc = jrpc;
            s_req = inst_req; s_aok = inst_addr_ok; s_dok = dok_real;
        end
    end

    // Fetch model: an instruction is delivered at the first unstalled edge at
    // which its data (or its address error) is available; a redirect seen while
    // it was in flight picks the PC after it.
    initial begin : model
        logic [31:0] cur_pc, ptgt, tgt, e_pc, e_inst;
        logic        started, outst, avail, pend, e_valid, e_adel;
        logic        deliver, dok, live, misal;
        cur_pc = RST_PC; ptgt = 32'h0; e_pc = 32'h0; e_inst = 32'h0;
        started = 1'b0; outst = 1'b0; avail = 1'b0; pend = 1'b0;
        e_valid = 1'b0; e_adel = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (s_reset) begin
                cur_pc = RST_PC; started = 1'b0; outst = 1'b0; avail = 1'b0;
                pend = 1'b0; e_valid = 1'b0;
                check("rst_valid", 32'(o_valid), 32'h0);
                check("rst_inst", o_inst, 32'h0);
                check("rst_pc", o_pc, 32'h0);
                check("rst_adel", 32'(o_adel), 32'h0);
                check("rst_req", 32'(inst_req), 32'h0);
            end else begin
                deliver = 1'b0;
                misal   = (cur_pc[1:0] != 2'b00);
                if (!started) begin
                    started = 1'b1;
                end else begin
                    dok = s_dok && outst;
                    if (!s_stall && (avail || dok || misal)) deliver = 1'b1;
                    else if (dok) avail = 1'b1;
                    if (s_req && s_aok) outst = 1'b1;
                    if (dok) outst = 1'b0;
                end
                live = s_idv && (s_pcs != 2'b00);
                tgt  = (s_pcs == 2'b01) ? s_bpc : (s_pcs == 2'b10) ? s_jrpc : s_jpc;
                if (deliver) begin
                    e_valid = 1'b1; e_pc = cur_pc; e_adel = misal;
                    e_inst  = misal ? 32'h0 : mem_word(cur_pc);
                    avail   = 1'b0;
                    cur_pc  = pend ? ptgt : (live ? tgt : cur_pc + 32'd4);
                    pend    = 1'b0;
                end else begin
                    if (live) begin pend = 1'b1; ptgt = tgt; end
                    if (!s_stall) e_valid = 1'b0;
                end
                check("o_valid", 32'(o_valid), 32'(e_valid));
                if (e_valid) begin
                    check("o_pc", o_pc, e_pc);
                    check("o_inst", o_inst, e_inst);
                    check("o_adel", 32'(o_adel), 32'(e_adel));
                end
                check("inst_req", 32'(inst_req),
                      32'(started && !outst && !avail && (cur_pc[1:0] == 2'b00)));
                if (inst_req) check("inst_addr", inst_addr, cur_pc);
            end
        end
    end

    initial begin
        reset = 1'b1; stall = 1'b0; id_valid = 1'b0; pcsource = 2'b00;
        bpc = 32'h0; jpc = 32'h0; jrpc = 32'h0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // boot fetch
        wait_pc(RST_PC);
        check("boot_inst", o_inst, 32'h2401_0001);
        @(negedge clk); #3;
        wait_req();
        check("boot_next_addr", inst_addr, 32'hBFC0_0004);

        // branch in decode while the delay slot waits three cycles
        wait_pc(32'hBFC0_0004);
        @(negedge clk);
        id_valid = 1'b1; pcsource = 2'b01; bpc = 32'hBFC0_0100; data_delay = 2;
        wait_pc(32'hBFC0_0008);
        check("dslot_inst", o_inst, 32'hADF4_5670);
        @(negedge clk);
        id_valid = 1'b0; pcsource = 2'b00; data_delay = 0;
        #3;
        wait_req();
        check("branch_addr", inst_addr, 32'hBFC0_0100);

        // stall over the returning data
        wait_pc(32'hBFC0_0100);
        for (int i = 0; i < 10 && !inst_data_ok; i++) begin
            @(negedge clk); #2;
        end
        stall = 1'b1;
        repeat (4) begin
            @(posedge clk); #3;
            check("stall_pc", o_pc, 32'hBFC0_0100);
            check("stall_inst", o_inst, 32'hADF4_5778);
            check("stall_req", 32'(inst_req), 32'h0);
        end
        @(negedge clk);
        stall = 1'b0;
        @(posedge clk); #3;
        check("unstall_valid", 32'(o_valid), 32'h1);
        check("unstall_pc", o_pc, 32'hBFC0_0104);
        check("unstall_inst", o_inst, 32'hADF4_577C);

        // jr to a misaligned address, then jump away
        @(negedge clk);
        id_valid = 1'b1; pcsource = 2'b10; jrpc = 32'hBFC0_0202;
        wait_pc(32'hBFC0_0108);
        @(negedge clk);
        id_valid = 1'b0; pcsource = 2'b00;
        wait_pc(32'hBFC0_0202);
        check("adel_flag", 32'(o_adel), 32'h1);
        check("adel_inst", o_inst, 32'h0);
        check("adel_noreq", 32'(inst_req), 32'h0);
        @(negedge clk);
        id_valid = 1'b1; pcsource = 2'b11; jpc = 32'hBFC0_0300;
        @(negedge clk);
        id_valid = 1'b0; pcsource = 2'b00;
        #3;
        check("adel2_pc", o_pc, 32'hBFC0_0206);
        check("adel2_flag", 32'(o_adel), 32'h1);
        check("jump_addr", inst_addr, 32'hBFC0_0300);

        // addr_ok withheld for five cycles
        wait_pc(32'hBFC0_0300);
        @(negedge clk);
        aok_hold = 5;
        repeat (5) begin
            #3;
            check("hold_req", 32'(inst_req), 32'h1);
            check("hold_addr", inst_addr, 32'hBFC0_0304);
            check("hold_aok", 32'(inst_addr_ok), 32'h0);
            @(negedge clk);
        end
        wait_pc(32'hBFC0_0304);
        check("held_inst", o_inst, 32'hADF4_557C);

        // reset while waiting for data, then a stale data_ok
        @(negedge clk);
        data_delay = 3;
        #3;
        wait_req();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1; data_delay = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0; stale_dok = 1'b1; aok_hold = 3;
        repeat (2) @(negedge clk);
        stale_dok = 1'b0;
        #3;
        check("stale_valid", 32'(o_valid), 32'h0);
        check("stale_pc", o_pc, 32'h0);
        check("stale_inst", o_inst, 32'h0);
        wait_req();
        check("rerun_addr", inst_addr, RST_PC);
        wait_pc(RST_PC);
        check("rerun_inst", o_inst, 32'h2401_0001);

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
